// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the sequential 32x32 multiplier.
package mul_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        StIdle,
        StNegA,
        StNegB,
        StMul,
        StNegLo,
        StNegHi,
        StDone
    } state_e;

endpackage

// File: rtl/mul32_seq.sv
// Multi-cycle shift-and-add 32x32->64 multiplier that borrows the shared external adder
// for operand magnitudes, partial-product accumulation and final product negation.
module mul32_seq #(
    parameter int unsigned WIDTH = mul_pkg::WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_c0,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c32,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             zero,
    output logic             ovf32
);
    import mul_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d, q_q, q_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d, prod_lo_q, prod_lo_d;
    logic             sgn_q, sgn_d, neg_q, neg_d, k_q, k_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic neg_opa, neg_opb, last_iter;

    assign neg_opa   = sgn_q & a_q[WIDTH-1];
    assign neg_opb   = sgn_q & b_q[WIDTH-1];
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign prod_hi   = prod_hi_q;
    assign prod_lo   = prod_lo_q;
    assign zero      = zero_q;
    assign ovf32     = ovf_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        neg_d     = neg_q;
        m_d       = m_q;
        q_d       = q_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        add_a     = '0;
        add_b     = '0;
        add_c0    = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d = StNegA;
                end
            end
            StNegA: begin
                // 0x80000000 negates to itself and is then read as unsigned 2^31.
                add_a   = neg_opa ? ~a_q : a_q;
                add_c0  = neg_opa;
                m_d     = add_s;
                state_d = StNegB;
            end
            StNegB: begin
                add_a   = neg_opb ? ~b_q : b_q;
                add_c0  = neg_opb;
                q_d     = add_s;
                hi_d    = '0;
                cnt_d   = '0;
                state_d = StMul;
            end
            StMul: begin
                // {HI,Q} shifts right with the adder carry-out entering HI's MSB.
                add_a = hi_q;
                add_b = q_q[0] ? m_q : '0;
                hi_d  = {add_c32, add_s[WIDTH-1:1]};
                q_d   = {add_s[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StNegLo;
                end
            end
            StNegLo: begin
                add_a   = neg_q ? ~q_q : q_q;
                add_c0  = neg_q;
                lo_d    = add_s;
                k_d     = add_c32;
                state_d = StNegHi;
            end
            StNegHi: begin
                // Low-word carry completes the 64-bit two's-complement negation.
                add_a     = neg_q ? ~hi_q : hi_q;
                add_c0    = neg_q & k_q;
                hi_d      = add_s;
                prod_hi_d = add_s;
                prod_lo_d = lo_q;
                zero_d    = (add_s == '0) && (lo_q == '0);
                ovf_d     = sgn_q ? (add_s != {WIDTH{lo_q[WIDTH-1]}}) : (add_s != '0);
                state_d   = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            m_q       <= '0;
            q_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            k_q       <= 1'b0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            neg_q     <= neg_d;
            m_q       <= m_d;
            q_q       <= q_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq with a behavioural 32-bit adder and a product scoreboard.
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_signed;
    logic [31:0] a, b;
    logic [31:0] add_a, add_b, add_s;
    logic        add_c0, add_c32;
    logic        out_valid, out_ready;
    logic [31:0] prod_hi, prod_lo;
    logic        zero, ovf32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared parallel-carry adder.
    assign {add_c32, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_c0};

    mul32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c0    (add_c0),
        .add_s     (add_s),
        .add_c32   (add_c32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .zero      (zero),
        .ovf32     (ovf32)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t   e;
        longint sx, sy;
        logic [63:0] p;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = 64'(sx * sy);
        end else begin
            p = {32'b0, x} * {32'b0, y};
        end
        e.hi   = p[63:32];
        e.lo   = p[31:0];
        e.zero = (p == 64'b0);
        e.ovf  = s ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'b0);
        return e;
    endfunction

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int hold, input bit pulse, input string tag);
        exp_t e;
        int   lat;
        check({tag, " in_ready_before"}, 80'(in_ready), 80'(1));
        a         = x;
        b         = y;
        is_signed = s;
        in_valid  = 1'b1;
        exp_q.push_back(model(x, y, s));
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (pulse && (k % 5 == 0)) begin
                in_valid = 1'b1;
                a        = $urandom;
                b        = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 80'(lat), 80'(37));
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 80'(0), 80'(1));
            return;
        end
        e = exp_q.pop_front();
        check({tag, " prod_hi"}, 80'(prod_hi), 80'(e.hi));
        check({tag, " prod_lo"}, 80'(prod_lo), 80'(e.lo));
        check({tag, " zero"}, 80'(zero), 80'(e.zero));
        check({tag, " ovf32"}, 80'(ovf32), 80'(e.ovf));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold_stable"},
                  80'({out_valid, in_ready, prod_hi, prod_lo, zero, ovf32}),
                  80'({1'b1, 1'b0, e.hi, e.lo, e.zero, e.ovf}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " after_handshake"},
              80'({out_valid, in_ready, prod_hi, prod_lo, zero, ovf32}),
              80'({1'b0, 1'b1, e.hi, e.lo, e.zero, e.ovf}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_handshake", 80'({in_ready, out_valid}), 80'({1'b1, 1'b0}));
        check("reset_prod", 80'({prod_hi, prod_lo}), 80'(0));
        check("reset_flags", 80'({zero, ovf32}), 80'(0));
        check("idle_adder_ports", 80'({add_a, add_b, add_c0}), 80'(0));

        do_op(32'd3, 32'd5, 1'b0, 0, 1'b0, "u3x5");
        do_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 1'b0, "s_m3x5");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10, 1'b1, "u_max_sq");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, "s_min_sq");
        do_op(32'h0000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, "s_zero_min");
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 2, 1'b0, "s_max_min");
        for (int i = 0; i < 4; i++) begin
            do_op($urandom, $urandom, 1'(i), 1, 1'b1, "random");
        end

        // Abort an operation partway through the MUL phase.
        a         = 32'h1234_5678;
        b         = 32'h9ABC_DEF0;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_handshake", 80'({in_ready, out_valid}), 80'({1'b1, 1'b0}));
        check("abort_prod", 80'({prod_hi, prod_lo}), 80'(0));
        do_op(32'd7, 32'd6, 1'b0, 0, 1'b0, "u7x6_after_abort");
        check("u7x6_lo_literal", 80'(prod_lo), 80'(32'h2A));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul32_seq.md
Name: mul32_seq

Overview:
Multi-cycle 32x32 to 64-bit shift-and-add multiplier for the ALU datapath.
- It does not contain its own adder. It drives the shared 32-bit parallel-carry adder through ports (add_a, add_b, add_c0) and consumes its sum and carry-out (add_s, add_c32) in the same cycle.
- It is therefore both the adder's upstream operand source and its downstream consumer.
- Operand and product negation for signed mode also go through the adder, using c0 as the +1.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported because the adder is fixed-width. Product is 2*WIDTH.
- ITER, WIDTH, number of add/shift iterations.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands offered.
- in_ready  out  1  block can accept operands (high only in IDLE).
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- a  in  32  multiplicand.
- b  in  32  multiplier.
- add_a  out  32  adder operand A (combinational from state).
- add_b  out  32  adder operand B.
- add_c0  out  1  adder carry-in.
- add_s  in  32  adder sum.
- add_c32  in  1  adder carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- prod_hi  out  32  product bits 63:32.
- prod_lo  out  32  product bits 31:0.
- zero  out  1  product == 0.
- ovf32  out  1  product does not fit in 32 bits.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1.
  - out_valid=0, prod_hi=0, prod_lo=0, zero=0, ovf32=0.
  - All internal registers are cleared.
- Reset mid-operation aborts the operation with no result.
- Accept: the cycle with in_valid & in_ready latches a, b, is_signed, and neg = is_signed & (a[31]^b[31]). Next state is NEG_A.
- in_valid is ignored in every non-IDLE state.
- NEG_A (1 cycle):
  - Drive add_a = (is_signed & a[31]) ? ~a : a, add_b = 0, add_c0 = is_signed & a[31].
  - Latch M = add_s, the magnitude.
  - 0x80000000 yields 0x80000000, which is treated as unsigned 2^31.
- NEG_B (1 cycle): same treatment for b. Latch Q = add_s. Clear HI=0 and the iteration count.
- MUL (ITER cycles):
  - Drive add_a = HI, add_b = Q[0] ? M : 0, add_c0 = 0.
  - Register {HI,Q} <= {add_c32, add_s, Q} >> 1, so the carry-out enters HI[31].
  - After the 32nd iteration go to NEG_LO.
- NEG_LO:
  - Drive add_a = neg ? ~Q : Q, add_b = 0, add_c0 = neg.
  - Latch LO = add_s and k = add_c32.
- NEG_HI:
  - Drive add_a = neg ? ~HI : HI, add_b = 0, add_c0 = neg & k.
  - Latch HI = add_s.
  - Go to DONE and set out_valid=1.
- DONE:
  - prod_hi/prod_lo are registered.
  - zero = ({HI,LO} == 0).
  - ovf32 = unsigned ? (HI != 0) : (HI != {32{LO[31]}}).
  - Outputs and flags are stable while out_valid=1.
- out_valid & out_ready moves to IDLE and clears out_valid. Outputs hold their values until the next DONE.
- A new operation cannot be accepted in the handoff cycle; in_ready rises the cycle after.
- Fixed latency: the accept at cycle 0 gives out_valid=1 at cycle 37 (NEG_A 1, NEG_B 2, MUL 3..34, NEG_LO 35, NEG_HI 36). No early exit for zero operands.
- Outside NEG_A..NEG_HI, add_a = add_b = 0 and add_c0 = 0.
- Every add_a/add_b/add_c0 value is a function of registered state only. There is no combinational path from add_s back to add_a, add_b or add_c0.

Decomposition:
- Package mul_pkg holds:
  - WIDTH.
  - State encoding: IDLE, NEG_A, NEG_B, MUL, NEG_LO, NEG_HI, DONE.
  - ITER counter width (6 bits).
- No sub-module. A single FSM plus datapath. The adder is instantiated by the parent, not inside this block.
- The bench instantiates the existing adder alongside the block.

Test Plan:
- Unsigned 3 x 5 -> out_valid exactly 37 cycles after accept; prod_hi=0x00000000, prod_lo=0x0000000F, zero=0, ovf32=0.
- Signed -3 (0xFFFFFFFD) x 5 -> prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFF1, ovf32=0.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001, ovf32=1. This checks carry into HI[31] during MUL.
- Signed 0x80000000 x 0x80000000 -> prod_hi=0x40000000, prod_lo=0x00000000, ovf32=1. Signed 0 x 0x80000000 -> all zero, zero=1, and neg must not produce 2^64 wrap garbage.
- Back-pressure and busy:
  - Hold out_ready=0 for 10 cycles: outputs remain stable and in_ready=0.
  - in_valid pulses while busy are ignored.
  - After the out_ready handshake, in_ready returns 1 on the next cycle.
- Assert rst for 1 cycle at MUL iteration 12 -> the next cycle shows in_ready=1, out_valid=0, prod=0. A following 7 x 6 unsigned gives prod_lo=0x2A.
